// File: rtl/onehot_line_encoder_if.sv
// Tile-side bus of the one-hot line encoder: io_in carries clock, reset and
// the six select lines; io_out carries the registered code/status byte.
interface onehot_line_encoder_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/onehot_line_encoder.sv
// Recovers the 3-bit line index from six asynchronous one-hot select lines,
// with a synchronizer, a stability filter and idle/valid/error classification.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | last accepted pattern had no bit set; code holds
// ST_VALID | last accepted pattern was one-hot; code = its index
// ST_ERROR | last accepted pattern had two or more bits set; code holds
module onehot_line_encoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  onehot_line_encoder_if.slave bus
);
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 15) begin : g_bad_param
    $error("STABLE_CYCLES must be in 2..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_ACC = 4'(STABLE_CYCLES - 1);

  logic       clk;
  logic       rst_n;
  logic [5:0] s1;
  logic [5:0] s2;
  logic [5:0] cand;
  logic [5:0] acc;
  logic [3:0] cnt;
  logic       accept;
  logic [2:0] ones;
  logic [2:0] idx;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       strobe_q, strobe_d;
  logic [1:0] evt_q, evt_d;

  assign clk   = bus.io_in[0];
  assign rst_n = bus.io_in[1];

  // s2 must match cand for CNT_ACC+1 consecutive compares before acceptance;
  // cnt saturates so a held pattern is accepted only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      cnt  <= '0;
      acc  <= '0;
    end else begin
      s1   <= bus.io_in[7:2];
      s2   <= s1;
      cand <= s2;
      if (s2 != cand) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 4'd1;
      end
      if (accept) begin
        acc <= cand;
      end
    end
  end

  assign accept = (s2 == cand) && (cnt == CNT_ACC);

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 6; i++) begin
      if (cand[i]) begin
        ones = ones + 3'd1;
        idx  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      strobe_q <= 1'b0;
      evt_q    <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      evt_q    <= evt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    strobe_d = 1'b0;
    evt_d    = evt_q;
    if (accept) begin
      if (ones == 3'd0) begin
        state_d = ST_IDLE;
      end else if (ones == 3'd1) begin
        state_d = ST_VALID;
        code_d  = idx;
        // Only a change to a different one-hot line counts as a new code.
        if (cand != acc) begin
          strobe_d = 1'b1;
          evt_d    = evt_q + 2'd1;
        end
      end else begin
        state_d = ST_ERROR;
      end
    end
  end

  assign bus.io_out = {evt_q, strobe_q, (state_q == ST_ERROR),
                       (state_q == ST_VALID), code_q};
endmodule

// File: tb/tb_onehot_line_encoder.sv
// Scoreboard bench for onehot_line_encoder: a run-length model of the input
// queues expected output bytes, compared every cycle, plus per-phase checks.
module tb_onehot_line_encoder;
  localparam int STABLE = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] lines;

  onehot_line_encoder_if bus ();
  assign bus.io_in = {lines, rst_n, clk};

  onehot_line_encoder #(.STABLE_CYCLES(STABLE)) dut (.bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] out;
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_strobe = 0;
  int         edge_n = 0;
  logic [7:0] exp_out = '0;

  logic [5:0] m_prev = '0;
  int         m_run = 0;
  logic [5:0] m_acc = '0;
  logic [2:0] m_code = '0;
  logic       m_valid = 1'b0;
  logic       m_err = 1'b0;
  logic [1:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, edge_n);
  endtask

  // A pattern is taken once it has been sampled STABLE+1 times in a row;
  // its effect shows on io_out two edges after that last sample.
  always @(posedge clk) begin
    logic [5:0] p;
    logic       stb;
    edge_n++;
    if (!rst_n) begin
      m_prev = '0; m_run = 0; m_acc = '0;
      m_code = '0; m_valid = 1'b0; m_err = 1'b0; m_cnt = '0;
    end else begin
      p = lines;
      if (p == m_prev) m_run++;
      else begin
        m_prev = p;
        m_run  = 1;
      end
      if (m_run == STABLE + 1) begin
        stb = 1'b0;
        if ($countones(p) == 0) begin
          m_valid = 1'b0; m_err = 1'b0;
        end else if ($countones(p) == 1) begin
          m_valid = 1'b1; m_err = 1'b0;
          for (int i = 0; i < 6; i++) if (p[i]) m_code = 3'(i);
          if (p != m_acc) begin
            stb   = 1'b1;
            m_cnt = m_cnt + 2'd1;
          end
        end else begin
          m_valid = 1'b0; m_err = 1'b1;
        end
        m_acc = p;
        sb_q.push_back('{edge_n + 2, {m_cnt, stb, m_err, m_valid, m_code}});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_out = '0;
    end else begin
      exp_out[5] = 1'b0;
      if (sb_q.size() > 0 && sb_q[0].due == edge_n) exp_out = sb_q.pop_front().out;
      chk("sb_out", bus.io_out, exp_out);
      if (bus.io_out[5]) n_strobe++;
    end
  end

  task automatic hold(input logic [5:0] p, input int n);
    lines = p;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic phase(input string tag, input logic [2:0] code, input logic valid,
                       input logic err, input logic [1:0] cnt, input int strobes,
                       input int s0);
    chk({tag, "_code"}, {5'd0, bus.io_out[2:0]}, {5'd0, code});
    chk({tag, "_valid"}, {7'd0, bus.io_out[3]}, {7'd0, valid});
    chk({tag, "_err"}, {7'd0, bus.io_out[4]}, {7'd0, err});
    chk({tag, "_cnt"}, {6'd0, bus.io_out[7:6]}, {6'd0, cnt});
    chk({tag, "_strobes"}, 8'(n_strobe - s0), 8'(strobes));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out", bus.io_out, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int s0;
    rst_n = 1'b0;
    lines = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", bus.io_out, 8'h00);
    rst_n = 1'b1;
    #1;

    s0 = n_strobe; hold(6'b001000, 12); phase("l3", 3'd3, 1, 0, 2'd1, 1, s0);
    s0 = n_strobe; hold(6'b010000, 10); phase("l4", 3'd4, 1, 0, 2'd2, 1, s0);
    s0 = n_strobe; hold(6'b110000, 4); hold(6'b100000, 10);
    phase("l5", 3'd5, 1, 0, 2'd3, 1, s0);
    s0 = n_strobe; hold(6'b000101, 10); phase("err", 3'd5, 0, 1, 2'd3, 0, s0);
    s0 = n_strobe; hold(6'b000000, 10); phase("idle", 3'd5, 0, 0, 2'd3, 0, s0);
    s0 = n_strobe; hold(6'b000010, 10); phase("l1", 3'd1, 1, 0, 2'd0, 1, s0);
    s0 = n_strobe; hold(6'b000100, 4); hold(6'b000010, 10);
    phase("glitch4", 3'd1, 1, 0, 2'd0, 0, s0);
    s0 = n_strobe; hold(6'b000100, 5); hold(6'b000010, 10);
    phase("glitch5", 3'd1, 1, 0, 2'd2, 2, s0);

    do_reset();
    s0 = n_strobe; hold(6'b000001, 8); phase("seq0", 3'd0, 1, 0, 2'd1, 1, s0);
    s0 = n_strobe; hold(6'b000100, 8); phase("seq2", 3'd2, 1, 0, 2'd2, 1, s0);
    s0 = n_strobe; hold(6'b010000, 8); phase("seq4", 3'd4, 1, 0, 2'd3, 1, s0);
    s0 = n_strobe; hold(6'b001000, 8); phase("seq3", 3'd3, 1, 0, 2'd0, 1, s0);
    s0 = n_strobe; hold(6'b100000, 8); phase("seq5", 3'd5, 1, 0, 2'd1, 1, s0);

    hold(6'b000010, 5);
    lines = 6'b000001;
    do_reset();
    s0 = n_strobe; hold(6'b000001, 10); phase("post_rst", 3'd0, 1, 0, 2'd1, 1, s0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
